tail_light_sequencer: RTL and testbench
=======================================

Name: tail_light_sequencer

Overview:
Sequencing controller for the 8-lamp rear light bar.
- Resolves raw driver requests (left, right, hazard, brake) into one active mode.
- Runs a prescaled sweep pattern per lamp group and drives `LEDS` directly.
- Decides when a mode change may take effect: turn sweeps complete before switching, hazard preempts immediately.
- Sits between the switch/debounce logic and the lamp drivers.

Parameters:
- TICK_DIV, default 4: clock cycles per sweep phase, minimum 2.
- CNT_W, default 8: prescaler counter width; must satisfy 2^CNT_W >= TICK_DIV.

Ports:
- clk     in   1  system clock, rising edge.
- reset   in   1  synchronous, active-high reset.
- left    in   1  left-turn request, level.
- right   in   1  right-turn request, level.
- hazard  in   1  hazard request, level.
- brake   in   1  brake request, level.
- LEDS    out  8  lamp drive. [7:4] = left group (bit 4 innermost), [3:0] = right group (bit 3 innermost).
- mode    out  2  active mode: 00 IDLE, 01 LEFT, 10 RIGHT, 11 HAZARD.

Behaviour:
- One clock (`clk`); `reset` is synchronous and active-high.
- Reset: LEDS=8'h00, mode=IDLE, phase=0, prescaler=0 at the next edge. Reset mid-sweep aborts the sweep immediately.
- Request resolution, priority order:
  - hazard=1, or left=1 and right=1 → HAZARD.
  - else left → LEFT.
  - else right → RIGHT.
  - else IDLE.
- Prescaler:
  - Counts 0..TICK_DIV-1; tick=1 when count==TICK_DIV-1, then wraps to 0.
  - Cleared to 0 on every mode change.
- Phase:
  - Counts 0..4, advancing only on tick; 4 wraps to 0.
  - Forced to 0 on every mode change.
- Mode transitions:
  - IDLE: when the resolved request is not IDLE, load it on the next edge with phase=0, count=0.
  - LEFT/RIGHT, hazard asserted: go to HAZARD on the next edge (preempt), phase=0, count=0.
  - LEFT/RIGHT, end of sweep (tick with phase==4): load the resolved request (may be IDLE or the other side), phase=0.
  - LEFT/RIGHT, request dropped mid-sweep: the sweep continues to its end.
  - HAZARD, end of sweep: load the resolved request.
  - HAZARD: no preemption; a hazard drop is honoured only at end of sweep.
- Sweep pattern per phase 0..4:
  - Left group [7:4]: 0000, 0001, 0011, 0111, 1111.
  - Right group [3:0]: 0000, 1000, 1100, 1110, 1111.
  - LEFT animates the left group only; RIGHT animates the right group only; HAZARD animates both groups in lockstep.
- Brake overlay, applied to any group not being animated:
  - IDLE+brake → 8'hFF.
  - LEFT+brake → right group 1111.
  - RIGHT+brake → left group 1111.
  - HAZARD ignores brake.
  - Without brake, non-animated groups = 0000.
- Latency:
  - `mode` is registered (1 cycle after the request edge).
  - `LEDS` is registered from the current mode/phase/brake (1 further cycle).
  - A brake change alone reaches `LEDS` in 1 cycle.
- Sweep period is 5*TICK_DIV cycles; phase 0 (all dark) lasts TICK_DIV cycles.
- Simultaneous events:
  - Request change coinciding with end of sweep: the newly resolved request wins.
  - hazard rising on the same edge as end of a turn sweep → HAZARD, phase 0 (same outcome either way).

Decomposition:
- Package tail_light_pkg:
  - mode encodings MODE_IDLE/LEFT/RIGHT/HAZARD.
  - PHASE_LAST=4.
  - Left/right pattern functions (phase → 4-bit nibble).
- Sub-module blink_prescaler (TICK_DIV, CNT_W), ports clk, reset, clr, tick.
- FSM, phase counter and output register stay in tail_light_sequencer.

Test Plan (TICK_DIV=4):
- reset, then left=1 held → mode=01 one cycle after the edge. LEDS sequence, each value 4 cycles: 00, 10, 30, 70, F0, repeats every 20 cycles.
- left=1 dropped after 6 cycles of LEFT → sweep runs to F0, held 4 cycles; then mode=IDLE, LEDS=00.
- LEFT at phase 2, hazard=1 pulse → next cycle mode=11, phase 0; LEDS 00, 18, 3C, 7E, FF; after the sweep, mode returns to LEFT (left still held).
- brake=1 in IDLE → LEDS=FF after 1 cycle. In RIGHT with brake=1, at phase 3 → LEDS=FE.
- left=1 and right=1 simultaneously from IDLE → mode=11. Releasing right mid-sweep → mode=01 only after phase 4 completes.
- reset=1 asserted at phase 3 of LEFT → next edge LEDS=00, mode=00. With left still held after reset release, the sweep restarts from phase 0.

Source files
------------

// File: rtl/tail_light_pkg.sv
// rtl/tail_light_pkg.sv - mode encodings, sweep length and lamp patterns for the tail light sequencer
package tail_light_pkg;

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'b00,
    MODE_LEFT   = 2'b01,
    MODE_RIGHT  = 2'b10,
    MODE_HAZARD = 2'b11
  } mode_t;

  localparam logic [2:0] PHASE_LAST = 3'd4;

  // Left group grows outward from bit 4, the innermost lamp.
  function automatic logic [3:0] left_pattern(input logic [2:0] phase);
    case (phase)
      3'd0:    left_pattern = 4'b0000;
      3'd1:    left_pattern = 4'b0001;
      3'd2:    left_pattern = 4'b0011;
      3'd3:    left_pattern = 4'b0111;
      default: left_pattern = 4'b1111;
    endcase
  endfunction

  // Right group grows outward from bit 3, the innermost lamp.
  function automatic logic [3:0] right_pattern(input logic [2:0] phase);
    case (phase)
      3'd0:    right_pattern = 4'b0000;
      3'd1:    right_pattern = 4'b1000;
      3'd2:    right_pattern = 4'b1100;
      3'd3:    right_pattern = 4'b1110;
      default: right_pattern = 4'b1111;
    endcase
  endfunction

  function automatic mode_t resolve(input logic left, input logic right, input logic hazard);
    if (hazard || (left && right)) resolve = MODE_HAZARD;
    else if (left)                 resolve = MODE_LEFT;
    else if (right)                resolve = MODE_RIGHT;
    else                           resolve = MODE_IDLE;
  endfunction

endpackage

// File: rtl/blink_prescaler.sv
// rtl/blink_prescaler.sv - free-running sweep-phase prescaler with synchronous clear
module blink_prescaler #(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  logic [CNT_W-1:0] count;

  assign tick = (count == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (reset || clr || tick) count <= '0;
    else                      count <= count + 1'b1;
  end

endmodule

// File: rtl/tail_light_sequencer.sv
// rtl/tail_light_sequencer.sv - resolves driver requests into a mode and drives the 8-lamp sweep
module tail_light_sequencer
  import tail_light_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int CNT_W    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       left,
  input  logic       right,
  input  logic       hazard,
  input  logic       brake,
  output logic [7:0] LEDS,
  output logic [1:0] mode
);

  mode_t      state;
  mode_t      next_state;
  mode_t      req;
  logic [2:0] phase;
  logic [7:0] leds_next;
  logic       tick;
  logic       clr;
  logic       end_sweep;

  blink_prescaler #(
    .TICK_DIV(TICK_DIV),
    .CNT_W   (CNT_W)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .tick (tick)
  );

  // Turn sweeps finish before switching; only a turn sweep can be preempted, and only by hazard.
  always_comb begin
    req        = resolve(left, right, hazard);
    end_sweep  = tick && (phase == PHASE_LAST);
    next_state = state;
    case (state)
      MODE_IDLE:              next_state = req;
      MODE_LEFT, MODE_RIGHT: begin
        if (hazard)         next_state = MODE_HAZARD;
        else if (end_sweep) next_state = req;
      end
      MODE_HAZARD:            if (end_sweep) next_state = req;
      default:                next_state = MODE_IDLE;
    endcase
    clr = (next_state != state);
  end

  // Brake lights whichever group the current mode is not animating.
  always_comb begin
    leds_next = 8'h00;
    case (state)
      MODE_IDLE:   leds_next = brake ? 8'hFF : 8'h00;
      MODE_LEFT:   leds_next = {left_pattern(phase), brake ? 4'hF : 4'h0};
      MODE_RIGHT:  leds_next = {brake ? 4'hF : 4'h0, right_pattern(phase)};
      MODE_HAZARD: leds_next = {left_pattern(phase), right_pattern(phase)};
      default:     leds_next = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MODE_IDLE;
      phase <= 3'd0;
      LEDS  <= 8'h00;
    end else begin
      state <= next_state;
      LEDS  <= leds_next;
      if (clr || state == MODE_IDLE) phase <= 3'd0;
      else if (tick)                 phase <= (phase == PHASE_LAST) ? 3'd0 : phase + 3'd1;
    end
  end

  assign mode = state;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// tb/tb_tail_light_sequencer.sv - scoreboard bench for tail_light_sequencer against a cycle-time reference model
module tb_tail_light_sequencer;

  localparam int TD     = 4;
  localparam int PERIOD = 5 * TD;

  logic       clk;
  logic       reset;
  logic       left;
  logic       right;
  logic       hazard;
  logic       brake;
  logic [7:0] LEDS;
  logic [1:0] mode;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [9:0] exp_q[$];

  logic [3:0] lp[5] = '{4'h0, 4'h1, 4'h3, 4'h7, 4'hF};
  logic [3:0] rp[5] = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF};

  // Model state: current mode (0 idle, 1 left, 2 right, 3 hazard), cycles spent in it, lamp outputs.
  int         m_mode = 0;
  int         m_t    = 0;
  logic [7:0] m_leds = 8'h00;

  tail_light_sequencer #(
    .TICK_DIV(TD),
    .CNT_W   (8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .left  (left),
    .right (right),
    .hazard(hazard),
    .brake (brake),
    .LEDS  (LEDS),
    .mode  (mode)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic drive(input bit r, input bit l, input bit rt, input bit hz, input bit bk);
    int         req;
    int         nm;
    int         ph;
    bit         eos;
    logic [7:0] nl;
    logic [1:0] mm;
    reset  = r;
    left   = l;
    right  = rt;
    hazard = hz;
    brake  = bk;
    req = (hz || (l && rt)) ? 3 : l ? 1 : rt ? 2 : 0;
    if (r) begin
      m_mode = 0;
      m_t    = 0;
      m_leds = 8'h00;
    end else begin
      ph = (m_t / TD) % 5;
      case (m_mode)
        0:       nl = bk ? 8'hFF : 8'h00;
        1:       nl = {lp[ph], bk ? 4'hF : 4'h0};
        2:       nl = {bk ? 4'hF : 4'h0, rp[ph]};
        default: nl = {lp[ph], rp[ph]};
      endcase
      eos = (m_t % PERIOD) == PERIOD - 1;
      nm  = m_mode;
      if (m_mode == 0)                         nm = req;
      else if ((m_mode == 1 || m_mode == 2) && hz) nm = 3;
      else if (eos)                            nm = req;
      m_t    = (nm != m_mode) ? 0 : m_t + 1;
      m_mode = nm;
      m_leds = nl;
    end
    mm = m_mode[1:0];
    exp_q.push_back({mm, m_leds});
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input int n, input bit l, input bit rt, input bit hz, input bit bk);
    for (int i = 0; i < n; i++) drive(1'b0, l, rt, hz, bk);
  endtask

  // Monitor: every clock edge presents a new registered output word.
  initial begin
    logic [9:0] e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks++;
        if (mode !== e[9:8]) begin
          failures++;
          $display("FAIL mode cyc=%0d got=%0h expected=%0h", cyc, mode, e[9:8]);
        end
        checks++;
        if (LEDS !== e[7:0]) begin
          failures++;
          $display("FAIL LEDS cyc=%0d got=%02h expected=%02h", cyc, LEDS, e[7:0]);
        end
      end
    end
  end

  initial begin
    bit l, rt, hz, bk;
    reset = 1'b1; left = 1'b0; right = 1'b0; hazard = 1'b0; brake = 1'b0;
    drive(1'b1, 0, 0, 0, 0);
    drive(1'b1, 0, 0, 0, 0);
    hold(3, 0, 0, 0, 0);
    hold(45, 1, 0, 0, 0);                  // left held: repeating sweeps
    hold(30, 0, 0, 0, 0);                  // drop mid-sweep, sweep completes
    hold(6, 1, 0, 0, 0);
    hold(30, 0, 0, 0, 0);
    hold(10, 1, 0, 0, 0);                  // hazard pulse at phase 2 of LEFT
    hold(1, 1, 0, 1, 0);
    hold(45, 1, 0, 0, 0);
    hold(12, 0, 0, 0, 0);
    hold(5, 0, 0, 0, 1);                   // brake in IDLE
    hold(25, 0, 1, 0, 1);                  // RIGHT with brake
    hold(25, 0, 0, 0, 0);
    hold(7, 1, 1, 0, 0);                   // both sides give HAZARD
    hold(35, 1, 0, 0, 0);
    hold(25, 0, 0, 0, 0);
    hold(13, 1, 0, 0, 0);
    drive(1'b1, 1, 0, 0, 0);               // reset mid-sweep
    hold(25, 1, 0, 0, 0);
    l = 0; rt = 0; hz = 0; bk = 0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(15) == 0) l  = ~l;
      if ($urandom_range(15) == 0) rt = ~rt;
      if ($urandom_range(31) == 0) hz = ~hz;
      if ($urandom_range(11) == 0) bk = ~bk;
      drive($urandom_range(499) == 0, l, rt, hz, bk);
    end
    hold(2, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
